// File: rtl/mem_a_loader.sv
// ---------------------------------------------------------------------------
// mem_a_loader
//   Upstream feeder for the A-matrix transpose-FIFO bank. Packs incoming
//   BEAT_ELEMS-wide beats into DIM-element rows and writes one row per WrEn
//   strobe. After row DIM-1 has been written, it holds the bank shift enable
//   for 2*DIM-1 cycles so that the skewed wavefront drains into the array.
//   It then pulses done for one cycle and returns to IDLE.
//
// Handshake: a beat transfers on a rising clk edge where in_valid && in_ready.
//   in_ready depends only on state and counters, never on in_valid. The
//   source may hold in_valid high indefinitely, and beats presented outside
//   LOAD are simply never taken.
//
// Ports
//   clk, rst      clock and asynchronous active-high reset
//   start         one-cycle load request, honoured in IDLE only
//   in_valid      beat valid
//   in_ready      beat ready
//   in_data       beat payload, element k at [k*BITS_AB +: BITS_AB]
//   Ain           packed row to the bank, element i at Ain[i]
//   Arow          row index for Ain
//   WrEn          one-cycle row write strobe
//   en            bank shift enable (STREAM only)
//   busy          high in any state other than IDLE
//   done          one-cycle pulse in DONE
//   stall_cycles  LOAD cycles with in_valid low (MEM_A_LOADER_PERF_EN only)
//   state_dbg     current FSM state encoding for observation
//
// Optional feature macro: MEM_A_LOADER_PERF_EN (adds stall_cycles).
// ---------------------------------------------------------------------------
module mem_a_loader #(
  parameter int BITS_AB    = 8,
  parameter int DIM        = 8,
  parameter int BEAT_ELEMS = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [BEAT_ELEMS*BITS_AB-1:0]       in_data,
  output logic signed [DIM-1:0][BITS_AB-1:0]  Ain,
  output logic [$clog2(DIM)-1:0]              Arow,
  output logic                                WrEn,
  output logic                                en,
  output logic                                busy,
  output logic                                done,
`ifdef MEM_A_LOADER_PERF_EN
  output logic [31:0]                         stall_cycles,
`endif
  output logic [1:0]                          state_dbg
);

  localparam int BPR = DIM / BEAT_ELEMS;             // beats per row
  localparam int BW  = (BPR > 1) ? $clog2(BPR) : 1;  // beat counter width
  localparam int RW  = $clog2(DIM + 1);              // row counter, saturates at DIM
  localparam int AW  = $clog2(DIM);                  // row index width
  localparam int SW  = $clog2(2 * DIM);              // stream counter width

  if ((DIM % BEAT_ELEMS) != 0) begin : g_bad_beat_elems
    $error("mem_a_loader: BEAT_ELEMS must divide DIM");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_STREAM = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                     state_q, state_d;
  logic [BW-1:0]              beat_q, beat_d;
  logic [RW-1:0]              row_q, row_d;
  logic [SW-1:0]              strm_q, strm_d;
  logic [DIM-1:0][BITS_AB-1:0] pack_q, pack_d;
  logic [DIM-1:0][BITS_AB-1:0] ain_q, ain_d;
  logic [AW-1:0]              arow_q, arow_d;
  logic                       wren_q, wren_d;
`ifdef MEM_A_LOADER_PERF_EN
  logic [31:0]                stall_q, stall_d;
`endif

  logic                        in_ready_c;
  logic                        accept;
  logic                        last_beat;
  logic [DIM-1:0][BITS_AB-1:0] row_next;

  // The packing buffer is separate from the Ain output register, so the
  // first beat of the next row can be taken while the previous row is being
  // written to the bank.
  always_comb begin
    in_ready_c = (state_q == S_LOAD) && (row_q != RW'(DIM));
    accept     = in_valid && in_ready_c;
    last_beat  = (beat_q == BW'(BPR - 1));

    // Row contents as they will be once the current beat is merged in.
    row_next = pack_q;
    for (int s = 0; s < DIM; s++) begin
      if (beat_q == BW'(s / BEAT_ELEMS)) begin
        row_next[s] = in_data[(s % BEAT_ELEMS)*BITS_AB +: BITS_AB];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    row_d   = row_q;
    strm_d  = strm_q;
    pack_d  = pack_q;
    ain_d   = ain_q;
    arow_d  = arow_q;
    wren_d  = 1'b0;
`ifdef MEM_A_LOADER_PERF_EN
    stall_d = stall_q;
`endif

    if (accept) begin
      pack_d = row_next;
      if (last_beat) begin
        beat_d = '0;
        ain_d  = row_next;
        arow_d = row_q[AW-1:0];
        wren_d = 1'b1;
        if (row_q != RW'(DIM)) begin
          row_d = row_q + RW'(1);
        end
      end else begin
        beat_d = beat_q + BW'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          beat_d  = '0;
          row_d   = '0;
          strm_d  = '0;
`ifdef MEM_A_LOADER_PERF_EN
          stall_d = '0;
`endif
        end
      end
      S_LOAD: begin
`ifdef MEM_A_LOADER_PERF_EN
        if (!in_valid && (stall_q != 32'hFFFF_FFFF)) begin
          stall_d = stall_q + 32'd1;
        end
`endif
        // Leave only once the final row's write strobe is on the bus, so
        // WrEn and en can never overlap.
        if (wren_q && (row_q == RW'(DIM))) begin
          state_d = S_STREAM;
          strm_d  = '0;
        end
      end
      S_STREAM: begin
        if (strm_q == SW'(2 * DIM - 2)) begin
          state_d = S_DONE;
          strm_d  = '0;
        end else begin
          strm_d = strm_q + SW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      row_q   <= '0;
      strm_q  <= '0;
      pack_q  <= '0;
      ain_q   <= '0;
      arow_q  <= '0;
      wren_q  <= 1'b0;
`ifdef MEM_A_LOADER_PERF_EN
      stall_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      row_q   <= row_d;
      strm_q  <= strm_d;
      pack_q  <= pack_d;
      ain_q   <= ain_d;
      arow_q  <= arow_d;
      wren_q  <= wren_d;
`ifdef MEM_A_LOADER_PERF_EN
      stall_q <= stall_d;
`endif
    end
  end

  assign in_ready  = in_ready_c;
  assign Ain       = ain_q;
  assign Arow      = arow_q;
  assign WrEn      = wren_q;
  assign en        = (state_q == S_STREAM);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign state_dbg = state_q;
`ifdef MEM_A_LOADER_PERF_EN
  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_mem_a_loader.sv
// ---------------------------------------------------------------------------
// tb_mem_a_loader
//   Directed bench for mem_a_loader (DIM=8, BITS_AB=8, BEAT_ELEMS=4).
//   Inputs change 1 time unit after each rising edge; outputs are read at
//   that same point, away from the edge.
// ---------------------------------------------------------------------------
module tb_mem_a_loader;

  localparam int BITS_AB    = 8;
  localparam int DIM        = 8;
  localparam int BEAT_ELEMS = 4;
  localparam int ROW_W      = DIM * BITS_AB;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                                start;
  logic                                in_valid;
  logic                                in_ready;
  logic [BEAT_ELEMS*BITS_AB-1:0]       in_data;
  logic signed [DIM-1:0][BITS_AB-1:0]  ain;
  logic [$clog2(DIM)-1:0]              arow;
  logic                                wren;
  logic                                en;
  logic                                busy;
  logic                                done;
  logic [1:0]                          state_dbg;
`ifdef MEM_A_LOADER_PERF_EN
  logic [31:0]                         stall_cycles;
`endif

  mem_a_loader #(
    .BITS_AB    (BITS_AB),
    .DIM        (DIM),
    .BEAT_ELEMS (BEAT_ELEMS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .Ain          (ain),
    .Arow         (arow),
    .WrEn         (wren),
    .en           (en),
    .busy         (busy),
    .done         (done),
`ifdef MEM_A_LOADER_PERF_EN
    .stall_cycles (stall_cycles),
`endif
    .state_dbg    (state_dbg)
  );

  // scoreboard
  logic [ROW_W-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [ROW_W-1:0] model_row(input logic [7:0] base, input int r);
    logic [ROW_W-1:0] v;
    v = '0;
    for (int i = 0; i < DIM; i++) v[i*BITS_AB +: BITS_AB] = base + 8'(r*DIM + i);
    return v;
  endfunction

  task automatic drive_beat(input logic [7:0] base, input int b);
    for (int k = 0; k < BEAT_ELEMS; k++)
      in_data[k*BITS_AB +: BITS_AB] = base + 8'(b*BEAT_ELEMS + k);
  endtask

  // One complete load/stream/done sequence starting from IDLE.
  // mode 0: back-to-back, 1: valid pattern 1,0,0,1, 2: stray starts,
  // mode 3: seven idle cycles early in LOAD.
  task automatic run_load(input int mode, input logic [7:0] base);
    int phase, beats, wr_rows, scnt, cyc, stall_exp;
    logic pend, acc, new_pend, exp_ready;
    start = 1'b1;
    in_valid = 1'b0;
    step();
    start = 1'b0;
    phase = 1; beats = 0; wr_rows = 0; scnt = 0; cyc = 0; stall_exp = 0; pend = 1'b0;
    exp_q.delete();
`ifdef MEM_A_LOADER_PERF_EN
    check("stall_clear_on_start", 64'(stall_cycles), 64'd0);
`endif
    while (1) begin
      exp_ready = (phase == 1) && (beats < 16);
      check("in_ready", 64'(in_ready), 64'(exp_ready));
      check("wren", 64'(wren), 64'(pend));
      check("en", 64'(en), 64'(phase == 2));
      check("done", 64'(done), 64'(phase == 3));
      check("busy", 64'(busy), 64'(phase != 0));
      if (pend) begin
        check("ain_row", 64'(ain), 64'(exp_q.pop_front()));
        check("arow", 64'(arow), 64'(wr_rows));
        wr_rows++;
      end
`ifdef MEM_A_LOADER_PERF_EN
      if (phase == 3) check("stall_cycles", 64'(stall_cycles), 64'(stall_exp));
`endif
      if (phase == 0) break;
      if (cyc > 300) begin
        check("timeout", 64'(cyc), 64'd0);
        break;
      end

      case (mode)
        1: in_valid = (cyc % 4 == 0) || (cyc % 4 == 3);
        3: in_valid = !(cyc >= 2 && cyc <= 8);
        default: in_valid = 1'b1;
      endcase
      drive_beat(base, beats);
      start = (mode == 2) && ((cyc == 3) || (phase == 2 && scnt == 0) || (phase == 3));

      if (phase == 1 && !in_valid) stall_exp++;
      acc = in_valid && exp_ready;
      new_pend = acc && (beats % 2 == 1);
      if (new_pend) exp_q.push_back(model_row(base, beats / 2));
      if (acc) beats++;

      case (phase)
        1: if (pend && wr_rows == DIM) begin phase = 2; scnt = 0; end
        2: begin scnt++; if (scnt == 2*DIM-1) phase = 3; end
        3: phase = 0;
        default: phase = 0;
      endcase
      pend = new_pend;
      step();
      cyc++;
    end
    start = 1'b0;
    in_valid = 1'b0;
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    check({tag, "_wren"}, 64'(wren), 64'd0);
    check({tag, "_en"}, 64'(en), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_ain"}, 64'(ain), 64'd0);
    check({tag, "_arow"}, 64'(arow), 64'd0);
    check({tag, "_state"}, 64'(state_dbg), 64'd0);
  endtask

  initial begin
    // reset held with valid and start asserted
    rst = 1'b1;
    start = 1'b1;
    in_valid = 1'b1;
    in_data = '1;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
`ifdef MEM_A_LOADER_PERF_EN
    check("reset_stall", 64'(stall_cycles), 64'd0);
`endif
    rst = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    step();
    check("idle_after_reset_busy", 64'(busy), 64'd0);

    // full back-to-back load, elements 0..63
    run_load(0, 8'd0);
    // valid gaps
    run_load(1, 8'd0);
    // start pulses in LOAD, STREAM and DONE are ignored
    run_load(2, 8'd64);

    // reset after five accepted beats
    start = 1'b1;
    step();
    start = 1'b0;
    in_valid = 1'b1;
    for (int b = 0; b < 5; b++) begin
      drive_beat(8'd160, b);
      step();
    end
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_idle_outputs("midload_reset");
    step();
    rst = 1'b0;
    step();
    // fresh load must start at row 0 with only new data
    run_load(0, 8'd100);

    // idle cycles during LOAD, then a clean load to clear the stall count
    run_load(3, 8'd200);
    run_load(0, 8'd7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
